// File: rtl/diff_integrator_pkg.sv
// Shared types and helpers for the difference-integrator stage.
// State encoding and the counter-width function live here so sibling stages agree.
package diff_integrator_pkg;

  typedef enum logic {
    DI_IDLE  = 1'b0,
    DI_ACCUM = 1'b1
  } di_state_e;

  // Ceiling log2, floored at 1 so a counter always has at least one bit.
  function automatic int di_clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/diff_integrator_sat_add.sv
// Combinational saturating adder: signed W-bit accumulator plus a (W+1)-bit
// pre-extended sample, clamped back to W bits with a saturation flag.
module sat_add #(
  parameter int W = 6
) (
  input  logic signed [W-1:0] acc,
  input  logic signed [W:0]   smp,
  output logic signed [W-1:0] sum,
  output logic                sat
);

  localparam logic signed [W:0] MAXV = {2'b00, {(W-1){1'b1}}};
  localparam logic signed [W:0] MINV = {2'b11, {(W-1){1'b0}}};

  logic signed [W:0] raw;

  // The sample is narrower than the accumulator, so W+1 bits never wrap.
  assign raw = {acc[W-1], acc} + smp;

  always_comb begin
    sat = 1'b0;
    sum = raw[W-1:0];
    if (raw > MAXV) begin
      sum = MAXV[W-1:0];
      sat = 1'b1;
    end else if (raw < MINV) begin
      sum = MINV[W-1:0];
      sat = 1'b1;
    end
  end

endmodule

// File: rtl/diff_integrator.sv
// Windowed integrator for the subtractor output: sums ACC_LEN ce-qualified samples
// per window with saturation, emitting one strobed result and an overflow flag.
module diff_integrator
  import diff_integrator_pkg::*;
#(
  parameter int IN_WIDTH     = 5,
  parameter     IN_IS_SIGNED = "TRUE",
  parameter int ACC_LEN      = 4,
  parameter int OUT_WIDTH    = 6
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ce,
  input  logic                        sync,
  input  logic [IN_WIDTH-1:0]         din,
  output logic signed [OUT_WIDTH-1:0] dout,
  output logic                        dout_valid,
  output logic                        overflow
);

  localparam int             CNT_W = di_clog2(ACC_LEN);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ACC_LEN - 1);

  di_state_e                   state, state_nx;
  logic signed [OUT_WIDTH-1:0] acc, acc_nx, acc_op, sum, dout_nx;
  logic [CNT_W-1:0]            cnt, cnt_nx;
  logic signed [OUT_WIDTH:0]   din_ext;
  logic                        sat_flag, sat_flag_nx, sat, vld_nx, ovf_nx, start;

  generate
    if (IN_IS_SIGNED == "TRUE") begin : g_sext
      assign din_ext = {{(OUT_WIDTH+1-IN_WIDTH){din[IN_WIDTH-1]}}, din};
    end else begin : g_zext
      assign din_ext = {{(OUT_WIDTH+1-IN_WIDTH){1'b0}}, din};
    end
  endgenerate

  // A qualified sync always opens a fresh window, so the adder sees a zero
  // accumulator; any partial sum in flight is dropped.
  assign start  = ce & sync;
  assign acc_op = start ? '0 : acc;

  sat_add #(.W(OUT_WIDTH)) u_sat_add (
    .acc (acc_op),
    .smp (din_ext),
    .sum (sum),
    .sat (sat)
  );

  always_comb begin
    state_nx    = state;
    acc_nx      = acc;
    cnt_nx      = cnt;
    sat_flag_nx = sat_flag;
    dout_nx     = dout;
    vld_nx      = 1'b0;
    ovf_nx      = overflow;
    if (start) begin
      state_nx    = DI_ACCUM;
      acc_nx      = sum;
      cnt_nx      = CNT_W'(1);
      sat_flag_nx = 1'b0;
    end else if (ce && state == DI_ACCUM) begin
      if (cnt == LAST) begin
        dout_nx     = sum;
        vld_nx      = 1'b1;
        ovf_nx      = sat_flag | sat;
        acc_nx      = '0;
        cnt_nx      = '0;
        sat_flag_nx = 1'b0;
      end else begin
        acc_nx      = sum;
        cnt_nx      = cnt + 1'b1;
        sat_flag_nx = sat_flag | sat;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= DI_IDLE;
      acc        <= '0;
      cnt        <= '0;
      sat_flag   <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state      <= state_nx;
      acc        <= acc_nx;
      cnt        <= cnt_nx;
      sat_flag   <= sat_flag_nx;
      dout       <= dout_nx;
      dout_valid <= vld_nx;
      overflow   <= ovf_nx;
    end
  end

endmodule
